alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// The arbiter takes the slave view; requesters, ALU and consumer take the master view.
interface alu_arbiter_if;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [2:0]  req0_op_i;
    logic [31:0] req0_a_i;
    logic [31:0] req0_b_i;
    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [2:0]  req1_op_i;
    logic [31:0] req1_a_i;
    logic [31:0] req1_b_i;
    logic [31:0] alu_data1_o;
    logic [31:0] alu_data2_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;
    logic        alu_zero_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_id_o;
    logic [31:0] rsp_data_o;
    logic        rsp_zero_o;
    logic        busy_o;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        input  alu_data_i, alu_zero_i, rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output alu_data1_o, alu_data2_o, alu_ctrl_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, busy_o
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        output alu_data_i, alu_zero_i, rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, busy_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: IDLE grants, EXEC waits the ALU latency, RESP holds the result.
module alu_arbiter #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_arbiter_if.slave  bus_s
);

    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        ptr_q;
    logic [2:0]  ctrl_q;
    logic [31:0] data1_q;
    logic [31:0] data2_q;
    logic        id_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_zero_q;
    logic        busy_q;

    logic        gnt0;
    logic        gnt1;
    logic [2:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  cnt_load_d;

    // ptr_q names the requester that wins the next tie (0 after reset).
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        sel_op = bus_s.req0_op_i;
        sel_a  = bus_s.req0_a_i;
        sel_b  = bus_s.req0_b_i;
        if (state_q == IDLE && !rst_i) begin
            if (bus_s.req0_valid_i && (!bus_s.req1_valid_i || !ptr_q)) begin
                gnt0 = 1'b1;
            end else if (bus_s.req1_valid_i) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt1) begin
            sel_op = bus_s.req1_op_i;
            sel_a  = bus_s.req1_a_i;
            sel_b  = bus_s.req1_b_i;
        end
        cnt_load_d = (sel_op == OP_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ptr_q       <= 1'b0;
            ctrl_q      <= 3'b000;
            data1_q     <= 32'd0;
            data2_q     <= 32'd0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        ctrl_q  <= sel_op;
                        data1_q <= sel_a;
                        data2_q <= sel_b;
                        id_q    <= gnt1;
                        ptr_q   <= gnt0;
                        cnt_q   <= cnt_load_d;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        rsp_data_q  <= bus_s.alu_data_i;
                        rsp_zero_q  <= bus_s.alu_zero_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (bus_s.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_s.req0_ready_o = gnt0;
    assign bus_s.req1_ready_o = gnt1;
    assign bus_s.alu_data1_o  = data1_q;
    assign bus_s.alu_data2_o  = data2_q;
    assign bus_s.alu_ctrl_o   = ctrl_q;
    assign bus_s.rsp_valid_o  = rsp_valid_q;
    assign bus_s.rsp_id_o     = id_q;
    assign bus_s.rsp_data_o   = rsp_data_q;
    assign bus_s.rsp_zero_o   = rsp_zero_q;
    assign bus_s.busy_o       = busy_q;

endmodule
